// File: rtl/song_streamer_pkg.sv
// Shared state encoding, default geometry and miss-counter arithmetic for the song streamer.
// Pure definitions: no latency, no flow control.
package song_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_TICK_DIV = 12500000;
    localparam int DEF_SONG_LEN = 64;
    localparam int DEF_LANE_LEN = 16;
    localparam int DEF_ADDR_W   = 6;
    localparam int STREAM_W     = 3;
    localparam int MISS_W       = 8;

    // Both lanes can miss on the same step, so the counter may need to absorb two at once.
    function automatic logic [MISS_W-1:0] sat_add2(input logic [MISS_W-1:0] cnt,
                                                   input logic a,
                                                   input logic b);
        logic [MISS_W:0] sum;
        sum = {1'b0, cnt} + {{MISS_W{1'b0}}, a} + {{MISS_W{1'b0}}, b};
        return sum[MISS_W] ? {MISS_W{1'b1}} : sum[MISS_W-1:0];
    endfunction

endpackage

// File: rtl/note_lane.sv
// One note lane: shift register with hit-clear of the lowest pending note near the marker; stream registered.
// Never stalls: shift, hit and clear are applied on the edge they are presented (hit clear before shift).
module note_lane
    import song_streamer_pkg::*;
#(
    parameter int LANE_LEN = DEF_LANE_LEN
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic                clear,
    input  logic                hit_en,
    input  logic                hit,
    input  logic                shift,
    input  logic                din,
    output logic [STREAM_W-1:0] stream,
    output logic                miss,
    output logic                empty
);

    logic [LANE_LEN-1:0] lane;
    logic [LANE_LEN-1:0] cleared;
    logic [STREAM_W-1:0] low;

    // x & (x-1) drops the oldest pending note inside the hit window only.
    always_comb begin
        low     = lane[STREAM_W-1:0];
        cleared = lane;
        if (hit_en && hit) begin
            cleared[STREAM_W-1:0] = low & (low - STREAM_W'(1));
        end
    end

    assign miss   = shift & cleared[0];
    assign empty  = (cleared == '0);
    assign stream = lane[STREAM_W-1:0];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            lane <= '0;
        end else if (clear) begin
            lane <= '0;
        end else if (shift) begin
            lane <= {din, cleared[LANE_LEN-1:1]};
        end else begin
            lane <= cleared;
        end
    end

endmodule

// File: rtl/song_streamer.sv
// Streams song ROM notes into two lanes at one step per TICK_DIV clocks, counting notes that leave unhit.
// ROM read latency is one clock (covered by LOAD); no backpressure, hits are single-cycle pulses.
module song_streamer
    import song_streamer_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int SONG_LEN = DEF_SONG_LEN,
    parameter int LANE_LEN = DEF_LANE_LEN,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic                start,
    input  logic [1:0]          song_data,
    input  logic                hit_l,
    input  logic                hit_r,
    output logic [ADDR_W-1:0]   song_addr,
    output logic [STREAM_W-1:0] stream_l,
    output logic [STREAM_W-1:0] stream_r,
    output logic                step,
    output logic                playing,
    output logic                done,
    output logic [MISS_W-1:0]   miss_count
);

    localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    state_t            state;
    logic [TICK_W-1:0] tick;
    logic              active;
    logic              shift;
    logic              clear_lanes;
    logic              din_l;
    logic              din_r;
    logic              miss_l;
    logic              miss_r;
    logic              empty_l;
    logic              empty_r;

    assign active      = (state == ST_PLAY) || (state == ST_DRAIN);
    assign shift       = active && (tick == TICK_LAST);
    assign clear_lanes = ((state == ST_IDLE) || (state == ST_DONE)) && start;
    assign din_l       = (state == ST_PLAY) & song_data[1];
    assign din_r       = (state == ST_PLAY) & song_data[0];

    note_lane #(.LANE_LEN(LANE_LEN)) u_lane_l (
        .clk    (clk),
        .reset_b(reset_b),
        .clear  (clear_lanes),
        .hit_en (active),
        .hit    (hit_l),
        .shift  (shift),
        .din    (din_l),
        .stream (stream_l),
        .miss   (miss_l),
        .empty  (empty_l)
    );

    note_lane #(.LANE_LEN(LANE_LEN)) u_lane_r (
        .clk    (clk),
        .reset_b(reset_b),
        .clear  (clear_lanes),
        .hit_en (active),
        .hit    (hit_r),
        .shift  (shift),
        .din    (din_r),
        .stream (stream_r),
        .miss   (miss_r),
        .empty  (empty_r)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state      <= ST_IDLE;
            tick       <= '0;
            song_addr  <= '0;
            miss_count <= '0;
            step       <= 1'b0;
            playing    <= 1'b0;
            done       <= 1'b0;
        end else begin
            step <= shift;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_LOAD;
                        tick       <= '0;
                        song_addr  <= '0;
                        miss_count <= '0;
                        playing    <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state <= ST_PLAY;
                    tick  <= '0;
                end
                ST_PLAY, ST_DRAIN: begin
                    tick <= shift ? '0 : tick + TICK_W'(1);
                    if (shift) begin
                        miss_count <= sat_add2(miss_count, miss_l, miss_r);
                        if (state == ST_PLAY) begin
                            if (song_addr == LAST_ADDR) begin
                                state <= ST_DRAIN;
                            end else begin
                                song_addr <= song_addr + ADDR_W'(1);
                            end
                        // Finish on the first drain step that finds both lanes already empty.
                        end else if (empty_l && empty_r) begin
                            state   <= ST_DONE;
                            playing <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    playing <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_streamer.sv
// Scoreboard bench for song_streamer: ROM 10,01,11,00 with TICK_DIV=LANE_LEN=SONG_LEN=4, plus a long saturating song.
module tb_song_streamer;

    localparam int TICK_DIV = 4;
    localparam int SONG_LEN = 4;
    localparam int LANE_LEN = 4;
    localparam int ADDR_W   = 2;

    typedef struct packed {
        logic [2:0] sl;
        logic [2:0] sr;
        logic [1:0] addr;
        logic [7:0] miss;
        logic       playing;
        logic       done;
    } exp_t;

    logic       clk       = 1'b0;
    logic       reset_b   = 1'b0;
    logic       start     = 1'b0;
    logic       hit_l     = 1'b0;
    logic       hit_r     = 1'b0;
    logic [1:0] song_data = 2'b00;
    logic [1:0] song_addr;
    logic [2:0] stream_l;
    logic [2:0] stream_r;
    logic       step;
    logic       playing;
    logic       done;
    logic [7:0] miss_count;

    logic       sat_start = 1'b0;
    logic [1:0] sat_data  = 2'b11;
    logic [6:0] sat_addr;
    logic [2:0] sat_sl;
    logic [2:0] sat_sr;
    logic       sat_step;
    logic       sat_playing;
    logic       sat_done;
    logic [7:0] sat_miss;

    logic [1:0] rom [4] = '{2'b10, 2'b01, 2'b11, 2'b00};

    // Per-step expectations: scenario 0 no hits, 1 left always hit, 2 right hit coincident with step 7.
    logic [2:0] sl_tab [3][8] = '{
        '{3'b000, 3'b100, 3'b010, 3'b101, 3'b010, 3'b001, 3'b000, 3'b000},
        '{3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000},
        '{3'b000, 3'b100, 3'b010, 3'b101, 3'b010, 3'b001, 3'b000, 3'b000}};
    logic [7:0] miss_tab [3][8] = '{
        '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd4, 8'd4},
        '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd2},
        '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd3}};
    logic [2:0] sr_tab   [8] = '{3'b000, 3'b000, 3'b100, 3'b110, 3'b011, 3'b001, 3'b000, 3'b000};
    logic [1:0] addr_tab [8] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    song_streamer #(
        .TICK_DIV(TICK_DIV), .SONG_LEN(SONG_LEN), .LANE_LEN(LANE_LEN), .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .start     (start),
        .song_data (song_data),
        .hit_l     (hit_l),
        .hit_r     (hit_r),
        .song_addr (song_addr),
        .stream_l  (stream_l),
        .stream_r  (stream_r),
        .step      (step),
        .playing   (playing),
        .done      (done),
        .miss_count(miss_count)
    );

    song_streamer #(
        .TICK_DIV(2), .SONG_LEN(128), .LANE_LEN(4), .ADDR_W(7)
    ) dut_sat (
        .clk       (clk),
        .reset_b   (reset_b),
        .start     (sat_start),
        .song_data (sat_data),
        .hit_l     (1'b0),
        .hit_r     (1'b0),
        .song_addr (sat_addr),
        .stream_l  (sat_sl),
        .stream_r  (sat_sr),
        .step      (sat_step),
        .playing   (sat_playing),
        .done      (sat_done),
        .miss_count(sat_miss)
    );

    always #5 clk = ~clk;

    always @(posedge clk) song_data <= rom[song_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_song(input int scen, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.sl      = sl_tab[scen][i];
            e.sr      = sr_tab[i];
            e.addr    = addr_tab[i];
            e.miss    = miss_tab[scen][i];
            e.playing = (i < 7);
            e.done    = (i == 7);
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge showing done (or after stop_after steps).
    task automatic run_song(input int scen, input int stop_after);
        int steps;
        int since;
        int cyc;
        bit fin;
        steps = 0; since = 0; cyc = 1; fin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_playing", 32'(playing), 1);
        check("load_addr", 32'(song_addr), 0);
        check("load_done", 32'(done), 0);
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            since++;
            hit_l = 1'b0;
            hit_r = 1'b0;
            if (step === 1'b1) begin
                steps++;
                since = 0;
                if (steps == 1) check("first_step_cycle", 32'(cyc), 6);
            end
            if (scen == 1) hit_l = (stream_l != 3'b000) || (step === 1'b1 && steps == 1);
            if (scen == 2) hit_r = (steps == 6 && since == 3);
            if (done === 1'b1 || (stop_after > 0 && steps == stop_after)) fin = 1'b1;
        end
        hit_l = 1'b0;
        hit_r = 1'b0;
        check("song_finished", 32'(fin), 1);
    endtask

    initial begin : monitor
        exp_t e;
        int   mcyc;
        int   last;
        bit   have_prev;
        mcyc = 0; last = 0; have_prev = 1'b0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (step === 1'b1) begin
                if (have_prev) check("step_interval", 32'(mcyc - last), TICK_DIV);
                last      = mcyc;
                have_prev = playing;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_step: step seen with no expectation queued");
                end else begin
                    e = exp_q.pop_front();
                    check("stream_l", 32'(stream_l), 32'(e.sl));
                    check("stream_r", 32'(stream_r), 32'(e.sr));
                    check("song_addr", 32'(song_addr), 32'(e.addr));
                    check("miss_count", 32'(miss_count), 32'(e.miss));
                    check("playing", 32'(playing), 32'(e.playing));
                    check("done", 32'(done), 32'(e.done));
                end
            end else if (playing !== 1'b1) begin
                have_prev = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int sat_steps;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(song_addr), 0);
        check("rst_stream_l", 32'(stream_l), 0);
        check("rst_stream_r", 32'(stream_r), 0);
        check("rst_step", 32'(step), 0);
        check("rst_playing", 32'(playing), 0);
        check("rst_done", 32'(done), 0);
        check("rst_miss", 32'(miss_count), 0);

        reset_b = 1'b1;
        push_song(0, 8);
        run_song(0, 0);
        check("a_done", 32'(done), 1);
        check("a_miss", 32'(miss_count), 4);
        check("a_streams", 32'({stream_l, stream_r}), 0);
        repeat (5) @(negedge clk);
        check("a_done_hold", 32'(done), 1);
        check("a_miss_hold", 32'(miss_count), 4);
        check("a_addr_hold", 32'(song_addr), 3);

        push_song(1, 8);
        run_song(1, 0);
        check("b_miss", 32'(miss_count), 2);

        push_song(2, 8);
        run_song(2, 0);
        check("c_miss", 32'(miss_count), 3);

        push_song(0, 2);
        run_song(0, 2);
        @(posedge clk);
        #2;
        reset_b = 1'b0;
        #1;
        check("arst_addr", 32'(song_addr), 0);
        check("arst_streams", 32'({stream_l, stream_r}), 0);
        check("arst_step", 32'(step), 0);
        check("arst_playing", 32'(playing), 0);
        check("arst_done", 32'(done), 0);
        check("arst_miss", 32'(miss_count), 0);
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        check("idle_playing", 32'(playing), 0);
        push_song(0, 8);
        run_song(0, 0);
        check("replay_miss", 32'(miss_count), 4);

        sat_start = 1'b1;
        @(negedge clk);
        sat_start = 1'b0;
        n = 0;
        sat_steps = 0;
        while (sat_done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
            if (sat_step === 1'b1) sat_steps++;
        end
        check("sat_done", 32'(sat_done), 1);
        check("sat_miss", 32'(sat_miss), 255);
        check("sat_steps", 32'(sat_steps), 133);
        check("sat_addr", 32'(sat_addr), 127);
        check("sat_streams", 32'({sat_sl, sat_sr}), 0);
        check("sat_playing", 32'(sat_playing), 0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
